audio_frame_sequencer: RTL and testbench

//  Sequences one stereo sample at a time through the audio path:

---
 rtl/audio_frame_sequencer.sv | 121 ++++++++++++
 tb/tb_audio_frame_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_sequencer.sv
// Moves one stereo sample per frame from the codec input FIFO, through an external
// processing block, into the codec output FIFO, with stall timeouts and event counters.
module audio_frame_sequencer #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              audio_in_available,
    input  logic [DATA_W-1:0] audio_in_L,
    input  logic [DATA_W-1:0] audio_in_R,
    output logic              read_audio_in,
    output logic              proc_in_valid,
    input  logic              proc_in_ready,
    output logic [DATA_W-1:0] proc_in_L,
    output logic [DATA_W-1:0] proc_in_R,
    input  logic              proc_out_valid,
    input  logic [DATA_W-1:0] proc_out_L,
    input  logic [DATA_W-1:0] proc_out_R,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [DATA_W-1:0] audio_out_L,
    output logic [DATA_W-1:0] audio_out_R,
    output logic              busy,
    output logic [CNT_W-1:0]  timeout_count,
    output logic [CNT_W-1:0]  drop_count
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_PROC, WRITE} state_t;

    localparam int              WC_W    = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t          state;
    logic [WC_W-1:0] wait_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            read_audio_in   <= 1'b0;
            write_audio_out <= 1'b0;
            proc_in_valid   <= 1'b0;
            proc_in_L       <= '0;
            proc_in_R       <= '0;
            audio_out_L     <= '0;
            audio_out_R     <= '0;
            timeout_count   <= '0;
            drop_count      <= '0;
        end else begin
            read_audio_in   <= 1'b0;
            write_audio_out <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (enable && audio_in_available) begin
                        proc_in_L     <= audio_in_L;
                        proc_in_R     <= audio_in_R;
                        read_audio_in <= 1'b1;
                        proc_in_valid <= 1'b1;
                        state         <= SEND;
                    end
                end
                // SEND and WAIT_PROC share one budget: wait_cnt keeps running across the accept.
                SEND: begin
                    if (proc_in_ready) begin
                        proc_in_valid <= 1'b0;
                        wait_cnt      <= wait_cnt + WC_W'(1);
                        state         <= WAIT_PROC;
                    end else if (wait_cnt >= WC_LAST) begin
                        proc_in_valid <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= IDLE;
                        if (timeout_count != '1)
                            timeout_count <= timeout_count + CNT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                WAIT_PROC: begin
                    if (proc_out_valid) begin
                        audio_out_L <= proc_out_L;
                        audio_out_R <= proc_out_R;
                        wait_cnt    <= '0;
                        state       <= WRITE;
                    end else if (wait_cnt >= WC_LAST) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                        if (timeout_count != '1)
                            timeout_count <= timeout_count + CNT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                WRITE: begin
                    if (audio_out_allowed) begin
                        write_audio_out <= 1'b1;
                        wait_cnt        <= '0;
                        state           <= IDLE;
                    end else if (wait_cnt >= WC_LAST) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                        if (drop_count != '1)
                            drop_count <= drop_count + CNT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench for audio_frame_sequencer with a one-cycle loopback processing model.
module tb_audio_frame_sequencer;

    localparam int DW = 32;
    localparam int TO = 16;
    localparam int CW = 2;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1, enable = 1'b0, audio_in_available = 1'b0;
    logic [DW-1:0] audio_in_L = '0, audio_in_R = '0;
    logic          read_audio_in, proc_in_valid, proc_in_ready = 1'b0;
    logic [DW-1:0] proc_in_L, proc_in_R;
    logic          proc_out_valid;
    logic [DW-1:0] proc_out_L, proc_out_R;
    logic          audio_out_allowed = 1'b0, write_audio_out;
    logic [DW-1:0] audio_out_L, audio_out_R;
    logic          busy;
    logic [CW-1:0] timeout_count, drop_count;

    logic          stall = 1'b0;
    logic          lb_valid = 1'b0;
    logic [DW-1:0] lb_L = '0, lb_R = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulse_err = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    int rd_c[$];
    int wr_c[$];
    logic [DW-1:0] wr_L[$];
    logic [DW-1:0] wr_R[$];

    audio_frame_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
        .audio_in_available(audio_in_available),
        .audio_in_L(audio_in_L), .audio_in_R(audio_in_R),
        .read_audio_in(read_audio_in),
        .proc_in_valid(proc_in_valid), .proc_in_ready(proc_in_ready),
        .proc_in_L(proc_in_L), .proc_in_R(proc_in_R),
        .proc_out_valid(proc_out_valid), .proc_out_L(proc_out_L), .proc_out_R(proc_out_R),
        .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
        .audio_out_L(audio_out_L), .audio_out_R(audio_out_R),
        .busy(busy), .timeout_count(timeout_count), .drop_count(drop_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Loopback processing: result appears the cycle after the handshake
    always @(posedge CLOCK_50) begin
        cyc      <= cyc + 1;
        lb_valid <= proc_in_valid & proc_in_ready;
        if (proc_in_valid & proc_in_ready) begin
            lb_L <= proc_in_L;
            lb_R <= proc_in_R;
        end
    end
    assign proc_out_valid = lb_valid & ~stall;
    assign proc_out_L     = lb_L;
    assign proc_out_R     = lb_R;

    always @(negedge CLOCK_50) begin
        if (read_audio_in) rd_c.push_back(cyc);
        if (write_audio_out) begin
            wr_c.push_back(cyc);
            wr_L.push_back(audio_out_L);
            wr_R.push_back(audio_out_R);
        end
        if ((read_audio_in && prev_rd) || (write_audio_out && prev_wr)) pulse_err++;
        prev_rd = read_audio_in;
        prev_wr = write_audio_out;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_avail(input logic [DW-1:0] l, input logic [DW-1:0] r);
        audio_in_L = l;
        audio_in_R = r;
        audio_in_available = 1'b1;
        tick();
        audio_in_available = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        audio_in_available = 1'b1;
        audio_in_L = 32'h1234_5678;
        repeat (3) tick();
        checks++;
        if ({busy, read_audio_in, write_audio_out, proc_in_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {busy, read_audio_in, write_audio_out, proc_in_valid});
        end
        checks++;
        if ({proc_in_L, proc_in_R, audio_out_L, audio_out_R, timeout_count, drop_count} !== '0) begin
            errors++;
            $display("FAIL reset_data: got pin=%h/%h aout=%h/%h to=%0d dr=%0d want all 0",
                     proc_in_L, proc_in_R, audio_out_L, audio_out_R, timeout_count, drop_count);
        end
        audio_in_available = 1'b0;
        enable = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        int nr, nw;
        nr = rd_c.size();
        nw = wr_c.size();
        enable = 1'b1;
        proc_in_ready = 1'b1;
        audio_out_allowed = 1'b1;
        pulse_avail(32'd1000, 32'hFFFF_FC18);
        repeat (6) tick();
        checks++;
        if (rd_c.size() - nr != 1 || wr_c.size() - nw != 1) begin
            errors++;
            $display("FAIL pass_counts: got reads=%0d writes=%0d want 1/1", rd_c.size() - nr, wr_c.size() - nw);
        end
        if (rd_c.size() > nr && wr_c.size() > nw) begin
            checks++;
            if (wr_c[nw] - rd_c[nr] != 3) begin
                errors++;
                $display("FAIL pass_latency: got %0d want 3", wr_c[nw] - rd_c[nr]);
            end
            checks++;
            if (wr_L[nw] !== 32'd1000 || wr_R[nw] !== 32'hFFFF_FC18) begin
                errors++;
                $display("FAIL pass_data: got %h/%h want 000003e8/fffffc18", wr_L[nw], wr_R[nw]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nw;
        nw = wr_c.size();
        audio_in_L = 32'h7FFF_FFFF;
        audio_in_R = 32'h8000_0000;
        audio_in_available = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) begin audio_in_L = 32'h8000_0000; audio_in_R = 32'h7FFF_FFFF; end
            if (i == 4) begin audio_in_L = 32'h0000_0001; audio_in_R = 32'hFFFF_FFFF; end
        end
        audio_in_available = 1'b0;
        repeat (6) tick();
        checks++;
        if (wr_c.size() - nw != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes want 3", wr_c.size() - nw);
        end else begin
            checks++;
            if (wr_c[nw+1] - wr_c[nw] != 4 || wr_c[nw+2] - wr_c[nw+1] != 4) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d,%0d want 4,4", wr_c[nw+1] - wr_c[nw], wr_c[nw+2] - wr_c[nw+1]);
            end
            checks++;
            if (wr_L[nw] !== 32'h7FFF_FFFF || wr_R[nw] !== 32'h8000_0000) begin
                errors++;
                $display("FAIL b2b_s0: got %h/%h want 7fffffff/80000000", wr_L[nw], wr_R[nw]);
            end
            checks++;
            if (wr_L[nw+1] !== 32'h8000_0000 || wr_R[nw+1] !== 32'h7FFF_FFFF) begin
                errors++;
                $display("FAIL b2b_s1: got %h/%h want 80000000/7fffffff", wr_L[nw+1], wr_R[nw+1]);
            end
            checks++;
            if (wr_L[nw+2] !== 32'h0000_0001 || wr_R[nw+2] !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL b2b_s2: got %h/%h want 00000001/ffffffff", wr_L[nw+2], wr_R[nw+2]);
            end
        end
    endtask

    task automatic test_output_drop();
        int nw;
        nw = wr_c.size();
        audio_out_allowed = 1'b0;
        pulse_avail(32'd5, 32'd6);
        repeat (TO + 1) tick();
        checks++;
        if (busy !== 1'b1 || drop_count !== 2'd0) begin
            errors++;
            $display("FAIL drop_before: got busy=%b drop=%0d want 1/0", busy, drop_count);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || drop_count !== 2'd1 || wr_c.size() != nw) begin
            errors++;
            $display("FAIL drop_at: got busy=%b drop=%0d writes=%0d want 0/1/0", busy, drop_count, wr_c.size() - nw);
        end
        audio_out_allowed = 1'b1;
        pulse_avail(32'd7, 32'd8);
        repeat (6) tick();
        checks++;
        if (wr_c.size() - nw != 1 || audio_out_L !== 32'd7 || audio_out_R !== 32'd8) begin
            errors++;
            $display("FAIL drop_recover: got writes=%0d out=%0d/%0d want 1/7/8", wr_c.size() - nw, audio_out_L, audio_out_R);
        end
    endtask

    task automatic test_proc_timeout();
        int nw;
        nw = wr_c.size();
        proc_in_ready = 1'b0;
        pulse_avail(32'd9, 32'd10);
        for (int k = 1; k < TO; k++) begin
            tick();
            checks++;
            if (proc_in_valid !== 1'b1 || proc_in_L !== 32'd9 || proc_in_R !== 32'd10) begin
                errors++;
                $display("FAIL send_hold[%0d]: got v=%b %0d/%0d want 1 9/10", k, proc_in_valid, proc_in_L, proc_in_R);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || proc_in_valid !== 1'b0 || timeout_count !== 2'd1) begin
            errors++;
            $display("FAIL send_timeout: got busy=%b v=%b to=%0d want 0/0/1", busy, proc_in_valid, timeout_count);
        end
        checks++;
        if (audio_out_L !== 32'd7 || audio_out_R !== 32'd8 || wr_c.size() != nw) begin
            errors++;
            $display("FAIL send_timeout_out: got %0d/%0d writes=%0d want 7/8/0", audio_out_L, audio_out_R, wr_c.size() - nw);
        end
    endtask

    task automatic test_combined_budget_saturation();
        proc_in_ready = 1'b1;
        stall = 1'b1;
        pulse_avail(32'd11, 32'd12);
        repeat (TO - 1) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL budget_before: got busy=%b want 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || timeout_count !== 2'd2) begin
            errors++;
            $display("FAIL budget_at: got busy=%b to=%0d want 0/2", busy, timeout_count);
        end
        proc_in_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            pulse_avail(32'd13, 32'd14);
            repeat (TO + 1) tick();
        end
        checks++;
        if (timeout_count !== 2'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL saturate: got to=%0d busy=%b want 3/0", timeout_count, busy);
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int nw;
        nw = wr_c.size();
        proc_in_ready = 1'b1;
        stall = 1'b1;
        pulse_avail(32'd21, 32'd22);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, read_audio_in, write_audio_out, proc_in_valid} !== 4'b0 ||
            {proc_in_L, proc_in_R, audio_out_L, audio_out_R, timeout_count, drop_count} !== '0) begin
            errors++;
            $display("FAIL midreset: got busy=%b pv=%b pin=%h aout=%h to=%0d dr=%0d want all 0",
                     busy, proc_in_valid, proc_in_L, audio_out_L, timeout_count, drop_count);
        end
        stall = 1'b0;
        repeat (5) tick();
        checks++;
        if (wr_c.size() != nw || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nowrite: got writes=%0d busy=%b want 0/0", wr_c.size() - nw, busy);
        end
    endtask

    task automatic test_enable_drop();
        int nr, nw;
        nr = rd_c.size();
        nw = wr_c.size();
        enable = 1'b1;
        proc_in_ready = 1'b0;
        audio_out_allowed = 1'b1;
        audio_in_L = 32'd31;
        audio_in_R = 32'd32;
        audio_in_available = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        proc_in_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (rd_c.size() - nr != 1 || wr_c.size() - nw != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_off: got reads=%0d writes=%0d busy=%b want 1/1/0", rd_c.size() - nr, wr_c.size() - nw, busy);
        end else begin
            checks++;
            if (wr_L[nw] !== 32'd31 || wr_R[nw] !== 32'd32) begin
                errors++;
                $display("FAIL enable_off_data: got %0d/%0d want 31/32", wr_L[nw], wr_R[nw]);
            end
        end
        audio_in_available = 1'b0;
        checks++;
        if (pulse_err != 0) begin
            errors++;
            $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", pulse_err);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_output_drop();
        test_proc_timeout();
        test_combined_budget_saturation();
        test_reset_mid_frame();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
